// File: rtl/nvdla_sdp_mrdma_eg_pkg.sv
// Shared types and field-layout helpers for the SDP MRDMA egress lane merger.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Command word layout (LSB first):
//   [MASK_LSB +: NUM_LANES]      lane mask
//   [len_lsb() +: BEAT_W]        beats-1
//   [last_bit()]                 last command of the layer
// Output word layout: {layer_end, mask, data}.
package nvdla_sdp_mrdma_eg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2
    } eg_state_e;

    // The lane mask always sits at the bottom of the command word.
    localparam int MASK_LSB = 0;

    // The remaining layout depends on the lane count and the length width
    // chosen by the instantiating module, so it is expressed as constant
    // functions rather than fixed numbers.
    function automatic int cmd_w(input int num_lanes, input int beat_w);
        return num_lanes + beat_w + 1;
    endfunction

    function automatic int len_lsb(input int num_lanes);
        return MASK_LSB + num_lanes;
    endfunction

    function automatic int last_bit(input int num_lanes, input int beat_w);
        return num_lanes + beat_w;
    endfunction

    function automatic int dout_w(input int num_lanes, input int atom_w);
        return num_lanes * atom_w + num_lanes + 1;
    endfunction

endpackage

// File: rtl/nvdla_sdp_mrdma_eg_pipe.sv
// Single-stage valid/ready output register of parametrised width.
// Latency: 1 cycle from src accept to dst_vld.
// Backpressure: src_rdy = !dst_vld || dst_rdy, so a full slot that is being drained accepts a new word in the same cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   src_vld/src_rdy/src_dat   upstream handshake and payload
//   dst_vld/dst_rdy/dst_dat   downstream handshake and registered payload
module nvdla_sdp_mrdma_eg_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         src_vld,
    output logic         src_rdy,
    input  logic [W-1:0] src_dat,
    output logic         dst_vld,
    input  logic         dst_rdy,
    output logic [W-1:0] dst_dat
);

    assign src_rdy = !dst_vld || dst_rdy;

    // Payload only moves on a load, so it stays put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_vld <= 1'b0;
            dst_dat <= '0;
        end else if (src_vld && src_rdy) begin
            dst_vld <= 1'b1;
            dst_dat <= src_dat;
        end else if (dst_rdy) begin
            dst_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/nvdla_sdp_mrdma_eg_lane_merge.sv
// SDP MRDMA egress: merges per-lane atom FIFOs into full-width beats under a mask/length command stream.
// Latency: 1 cycle from beat fire (joint lane pop) to dout_valid; 1 beat/cycle with dout_ready held high.
// Backpressure: lanes are popped only when every masked lane is valid and the output slot is free; cmd_prdy only in IDLE.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//   op_load                            layer start pulse, clears dp2reg_beat_num
//   cmd_pvld/cmd_prdy/cmd_pd           {last, beats-1, lane mask} command
//   pfifo_rd_pvld/prdy/pd              per-lane atom FIFO read side
//   dout_valid/dout_ready/dout_pd      {layer_end, mask, data} beat to the core mux
//   eg_done                            one-cycle layer-complete pulse
//   dp2reg_beat_num                    saturating beats-accepted count for this layer
module nvdla_sdp_mrdma_eg_lane_merge
    import nvdla_sdp_mrdma_eg_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int ATOM_W    = 64,
    parameter int BEAT_W    = 13
) (
    input  logic                                    nvdla_core_clk,
    input  logic                                    nvdla_core_rstn,
    input  logic                                    op_load,
    input  logic                                    cmd_pvld,
    output logic                                    cmd_prdy,
    input  logic [NUM_LANES+BEAT_W:0]               cmd_pd,
    input  logic [NUM_LANES-1:0]                    pfifo_rd_pvld,
    output logic [NUM_LANES-1:0]                    pfifo_rd_prdy,
    input  logic [NUM_LANES*ATOM_W-1:0]             pfifo_rd_pd,
    output logic                                    dout_valid,
    input  logic                                    dout_ready,
    output logic [NUM_LANES*ATOM_W+NUM_LANES:0]     dout_pd,
    output logic                                    eg_done,
    output logic [31:0]                             dp2reg_beat_num
);

    localparam int CMD_W    = cmd_w(NUM_LANES, BEAT_W);
    localparam int LEN_LSB  = len_lsb(NUM_LANES);
    localparam int LAST_BIT = last_bit(NUM_LANES, BEAT_W);
    localparam int DATA_W   = NUM_LANES * ATOM_W;
    localparam int DOUT_W   = dout_w(NUM_LANES, ATOM_W);

    // ------------------------------------------------------------------
    // Command unpacking
    // ------------------------------------------------------------------
    logic [CMD_W-1:0]     cmd_word;
    logic [NUM_LANES-1:0] cmd_mask;
    logic [BEAT_W-1:0]    cmd_len;
    logic                 cmd_last;

    assign cmd_word = cmd_pd;
    assign cmd_mask = cmd_word[MASK_LSB +: NUM_LANES];
    assign cmd_len  = cmd_word[LEN_LSB +: BEAT_W];
    assign cmd_last = cmd_word[LAST_BIT];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    eg_state_e            state;
    eg_state_e            state_nxt;
    logic [NUM_LANES-1:0] mask_q;
    logic [BEAT_W-1:0]    len_q;
    logic                 last_q;
    logic [BEAT_W-1:0]    beat_idx;

    logic                 cmd_acc;
    logic                 fire;
    logic                 skip_done;
    logic                 lanes_rdy;
    logic                 slot_free;
    logic                 last_beat;

    // A lane that is not in the mask counts as ready, so the beat waits only
    // on the lanes it actually consumes. Popping all masked lanes together
    // keeps them aligned atom-for-atom.
    assign lanes_rdy = &(pfifo_rd_pvld | ~mask_q);
    assign last_beat = (beat_idx == len_q);

    always_comb begin
        state_nxt = state;
        cmd_prdy  = 1'b0;
        cmd_acc   = 1'b0;
        fire      = 1'b0;
        skip_done = 1'b0;
        case (state)
            IDLE: begin
                cmd_prdy = 1'b1;
                if (cmd_pvld) begin
                    cmd_acc   = 1'b1;
                    state_nxt = (cmd_mask != '0) ? RUN : SKIP;
                end
            end
            RUN: begin
                fire = lanes_rdy && slot_free;
                if (fire && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            SKIP: begin
                // An all-zero mask produces no beats; a last-of-layer one
                // still has to close the layer.
                skip_done = last_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            mask_q   <= '0;
            len_q    <= '0;
            last_q   <= 1'b0;
            beat_idx <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_acc) begin
                mask_q   <= cmd_mask;
                len_q    <= cmd_len;
                last_q   <= cmd_last;
                beat_idx <= '0;
            end else if (fire) begin
                // Clear on the final beat instead of wrapping past len.
                beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
            end
        end
    end

    assign pfifo_rd_prdy = fire ? mask_q : '0;

    // ------------------------------------------------------------------
    // Beat assembly: unmasked lanes are forced to zero so stale FIFO heads
    // never leak downstream.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fill_dat;
    logic              layer_end;
    logic [DOUT_W-1:0] beat_dat;

    always_comb begin
        fill_dat = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_q[i]) begin
                fill_dat[i*ATOM_W +: ATOM_W] = pfifo_rd_pd[i*ATOM_W +: ATOM_W];
            end
        end
    end

    assign layer_end = last_q && last_beat;
    assign beat_dat  = {layer_end, mask_q, fill_dat};

    nvdla_sdp_mrdma_eg_pipe #(
        .W (DOUT_W)
    ) u_pipe (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .src_vld (fire),
        .src_rdy (slot_free),
        .src_dat (beat_dat),
        .dst_vld (dout_valid),
        .dst_rdy (dout_ready),
        .dst_dat (dout_pd)
    );

    // ------------------------------------------------------------------
    // Layer completion and status counter
    // ------------------------------------------------------------------
    logic        accept;
    logic        done_q;
    logic [31:0] beat_cnt;

    assign accept = dout_valid && dout_ready;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= accept && dout_pd[DOUT_W-1];
        end
    end

    // The two sources cannot normally overlap, but ORing them keeps a pulse
    // from being lost if they ever do.
    assign eg_done = done_q | skip_done;

    // op_load wins over increment; an accept in the same cycle is the first
    // beat of the new layer, hence 1 rather than 0.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            beat_cnt <= '0;
        end else if (op_load) begin
            beat_cnt <= accept ? 32'd1 : 32'd0;
        end else if (accept && (beat_cnt != 32'hFFFF_FFFF)) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

    assign dp2reg_beat_num = beat_cnt;

endmodule

// File: tb/tb_nvdla_sdp_mrdma_eg_lane_merge.sv
module tb_nvdla_sdp_mrdma_eg_lane_merge;

    localparam int NL = 4;
    localparam int AW = 16;
    localparam int BW = 13;
    localparam int DW = NL * AW + NL + 1;   // 69

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          op_load = 1'b0;
    logic          cmd_pvld = 1'b0;
    logic          cmd_prdy;
    logic [17:0]   cmd_pd = '0;
    logic [3:0]    pvld = '0;
    logic [3:0]    prdy;
    logic [63:0]   pd;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout_pd;
    logic          eg_done;
    logic [31:0]   beat_num;

    int total = 0;
    int bad   = 0;

    // Upstream lane FIFOs modelled as counters: each pop advances the head.
    logic [11:0] lane_cnt [4];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) lane_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (prdy[i] && pvld[i]) lane_cnt[i] <= lane_cnt[i] + 12'd1;
        end
    end

    always_comb begin
        pd = '0;
        for (int i = 0; i < 4; i++) pd[i*16 +: 16] = {4'(i), lane_cnt[i]};
    end

    nvdla_sdp_mrdma_eg_lane_merge #(
        .NUM_LANES (NL),
        .ATOM_W    (AW),
        .BEAT_W    (BW)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_load         (op_load),
        .cmd_pvld        (cmd_pvld),
        .cmd_prdy        (cmd_prdy),
        .cmd_pd          (cmd_pd),
        .pfifo_rd_pvld   (pvld),
        .pfifo_rd_prdy   (prdy),
        .pfifo_rd_pd     (pd),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_pd         (dout_pd),
        .eg_done         (eg_done),
        .dp2reg_beat_num (beat_num)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mkcmd(input logic last, input logic [12:0] len, input logic [3:0] m);
        return {last, len, m};
    endfunction

    function automatic logic [DW-1:0] beat(input logic le, input logic [3:0] m,
                                           input logic [11:0] c0, input logic [11:0] c1,
                                           input logic [11:0] c2, input logic [11:0] c3);
        logic [63:0] d;
        d = {4'd3, c3, 4'd2, c2, 4'd1, c1, 4'd0, c0};
        for (int i = 0; i < 4; i++) if (!m[i]) d[i*16 +: 16] = '0;
        return {le, m, d};
    endfunction

    // Move to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [47:0] lanes();
        return {lane_cnt[3], lane_cnt[2], lane_cnt[1], lane_cnt[0]};
    endfunction

    initial begin
        // ---------------- reset ----------------
        #12;
        chk("rst_dout_valid", DW'(dout_valid), DW'(0));
        chk("rst_dout_pd",    dout_pd,         DW'(0));
        chk("rst_eg_done",    DW'(eg_done),    DW'(0));
        chk("rst_beat_num",   DW'(beat_num),   DW'(0));
        chk("rst_prdy",       DW'(prdy),       DW'(0));
        chk("rst_cmd_prdy",   DW'(cmd_prdy),   DW'(1));
        rstn = 1'b1;
        step();

        // ---------------- full mask, 3 beats, last ----------------
        pvld = 4'hF; dout_ready = 1'b1;
        cmd_pd = mkcmd(1'b1, 13'd2, 4'hF); cmd_pvld = 1'b1;
        step();
        cmd_pvld = 1'b0; #1;
        chk("t1_prdy_run", DW'(prdy), DW'(4'hF));
        step();
        chk("t1_valid_b0", DW'(dout_valid), DW'(1));
        chk("t1_b0", dout_pd, beat(1'b0, 4'hF, 12'd0, 12'd0, 12'd0, 12'd0));
        step();
        chk("t1_b1", dout_pd, beat(1'b0, 4'hF, 12'd1, 12'd1, 12'd1, 12'd1));
        step();
        chk("t1_b2", dout_pd, beat(1'b1, 4'hF, 12'd2, 12'd2, 12'd2, 12'd2));
        chk("t1_prdy_idle", DW'(prdy), DW'(0));
        chk("t1_cmd_prdy", DW'(cmd_prdy), DW'(1));
        chk("t1_done_early", DW'(eg_done), DW'(0));
        step();
        chk("t1_done", DW'(eg_done), DW'(1));
        chk("t1_valid_off", DW'(dout_valid), DW'(0));
        chk("t1_cnt", DW'(beat_num), DW'(3));
        step();
        chk("t1_done_once", DW'(eg_done), DW'(0));
        chk("t1_lanes", DW'(lanes()), DW'({12'd3, 12'd3, 12'd3, 12'd3}));

        // ---------------- op_load, sparse mask 0101 ----------------
        op_load = 1'b1;
        step();
        op_load = 1'b0;
        chk("t2_opload_clr", DW'(beat_num), DW'(0));
        pvld = 4'b1101;
        cmd_pd = mkcmd(1'b1, 13'd0, 4'b0101); cmd_pvld = 1'b1;
        step();
        cmd_pvld = 1'b0; #1;
        chk("t2_prdy", DW'(prdy), DW'(4'b0101));
        step();
        chk("t2_beat", dout_pd, beat(1'b1, 4'b0101, 12'd3, 12'd3, 12'd3, 12'd3));
        chk("t2_prdy_idle", DW'(prdy), DW'(0));
        step();
        chk("t2_done", DW'(eg_done), DW'(1));
        chk("t2_cnt", DW'(beat_num), DW'(1));
        chk("t2_lanes", DW'(lanes()), DW'({12'd3, 12'd4, 12'd3, 12'd4}));

        // ---------------- mask 0011, lane1 late by 5 cycles ----------------
        pvld = 4'b0001;
        cmd_pd = mkcmd(1'b0, 13'd0, 4'b0011); cmd_pvld = 1'b1;
        step();
        cmd_pvld = 1'b0;
        repeat (5) begin
            #1;
            chk("t3_wait_prdy", DW'(prdy), DW'(0));
            chk("t3_wait_lane0", DW'(lane_cnt[0]), DW'(4));
            step();
        end
        pvld = 4'b0011; #1;
        chk("t3_joint_prdy", DW'(prdy), DW'(4'b0011));
        step();
        chk("t3_beat", dout_pd, beat(1'b0, 4'b0011, 12'd4, 12'd3, 12'd0, 12'd0));
        step();
        chk("t3_no_done", DW'(eg_done), DW'(0));
        chk("t3_lanes", DW'(lanes()), DW'({12'd3, 12'd4, 12'd4, 12'd5}));

        // ---------------- backpressure, 4 beats ----------------
        pvld = 4'hF;
        cmd_pd = mkcmd(1'b1, 13'd3, 4'hF); cmd_pvld = 1'b1;
        step();
        cmd_pvld = 1'b0;
        step();
        dout_ready = 1'b0; #1;
        chk("t4_stall_prdy", DW'(prdy), DW'(0));
        chk("t4_b0", dout_pd, beat(1'b0, 4'hF, 12'd5, 12'd4, 12'd4, 12'd3));
        repeat (4) begin
            step(); #1;
            chk("t4_hold_pd", dout_pd, beat(1'b0, 4'hF, 12'd5, 12'd4, 12'd4, 12'd3));
            chk("t4_hold_prdy", DW'(prdy), DW'(0));
        end
        dout_ready = 1'b1; #1;
        chk("t4_resume_prdy", DW'(prdy), DW'(4'hF));
        step();
        chk("t4_b1", dout_pd, beat(1'b0, 4'hF, 12'd6, 12'd5, 12'd5, 12'd4));
        step();
        chk("t4_b2", dout_pd, beat(1'b0, 4'hF, 12'd7, 12'd6, 12'd6, 12'd5));
        step();
        chk("t4_b3", dout_pd, beat(1'b1, 4'hF, 12'd8, 12'd7, 12'd7, 12'd6));
        step();
        chk("t4_done", DW'(eg_done), DW'(1));
        chk("t4_cnt", DW'(beat_num), DW'(6));
        chk("t4_lanes", DW'(lanes()), DW'({12'd7, 12'd8, 12'd8, 12'd9}));

        // ---------------- zero mask with last ----------------
        pvld = 4'b0000;
        cmd_pd = mkcmd(1'b1, 13'd0, 4'b0000); cmd_pvld = 1'b1;
        step();
        cmd_pd = mkcmd(1'b0, 13'd0, 4'b0001); #1;
        chk("t5_skip_cmd_prdy", DW'(cmd_prdy), DW'(0));
        chk("t5_skip_done", DW'(eg_done), DW'(1));
        chk("t5_skip_valid", DW'(dout_valid), DW'(0));
        chk("t5_skip_prdy", DW'(prdy), DW'(0));
        step(); #1;
        chk("t5_idle_cmd_prdy", DW'(cmd_prdy), DW'(1));
        chk("t5_done_once", DW'(eg_done), DW'(0));
        step();
        cmd_pvld = 1'b0; #1;
        chk("t5_next_accepted", DW'(cmd_prdy), DW'(0));
        pvld = 4'b0001; #1;
        chk("t5_next_prdy", DW'(prdy), DW'(4'b0001));
        step();
        chk("t5_next_beat", dout_pd, beat(1'b0, 4'b0001, 12'd9, 12'd0, 12'd0, 12'd0));
        step();
        chk("t5_cnt", DW'(beat_num), DW'(7));

        // ---------------- counter saturation and op_load with accept ----------------
        force dut.beat_cnt = 32'hFFFF_FFFE;
        step();
        release dut.beat_cnt;
        cmd_pd = mkcmd(1'b0, 13'd2, 4'b0001); cmd_pvld = 1'b1;
        step();
        cmd_pvld = 1'b0;
        step();
        chk("t6_b0", dout_pd, beat(1'b0, 4'b0001, 12'd10, 12'd0, 12'd0, 12'd0));
        step();
        chk("t6_cnt_max", DW'(beat_num), DW'(32'hFFFF_FFFF));
        step();
        chk("t6_cnt_sat", DW'(beat_num), DW'(32'hFFFF_FFFF));
        op_load = 1'b1;
        step();
        op_load = 1'b0;
        chk("t6_load_accept", DW'(beat_num), DW'(1));
        step();
        chk("t6_drained", DW'(dout_valid), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
